// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// Oversampling UART receiver for the host link.
//
// The line is resynchronised and then sampled OVERSAMPLE times per bit. Each
// bit is decided by a 2-of-3 majority vote of the three samples around the
// bit centre. The receiver supports optional odd/even parity and one or two
// stop bits. Each received word is delivered as a one-cycle axiov strobe.
// A frame of all zeros with a bad stop bit is reported as a break instead.
//
// Parameters
//   DATA_WIDTH  : data bits per frame (5..16), sent LSB first
//   CLK_FREQ_HZ : clk frequency in Hz
//   BAUDRATE    : line rate in bit/s
//   OVERSAMPLE  : ticks per bit; even and at least 8
//   PARITY      : 0 = none, 1 = odd, 2 = even
//   STOP_BITS   : 1 or 2
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rxd        : serial input; asynchronous to clk, idles high
//   axiod      : received word; holds its value between strobes
//   axiov      : one-cycle valid strobe for axiod, parity_err and frame_err
//   parity_err : parity mismatch; qualified by axiov
//   frame_err  : a stop bit was sampled low; qualified by axiov
//   break_det  : one-cycle pulse when a break condition is detected
//   busy       : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE    = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] axiod,
  output logic                  axiov,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  break_det,
  output logic                  busy
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int TICK_PERIOD = CLK_FREQ_HZ / (BAUDRATE * OVERSAMPLE);
  localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int OS_W        = $clog2(OVERSAMPLE);
  localparam int BIT_W       = $clog2(DATA_WIDTH);

  localparam logic [TICK_W-1:0] TICK_LAST =
    (TICK_PERIOD >= 1) ? TICK_W'(TICK_PERIOD - 1) : '0;
  localparam logic [OS_W-1:0]   OS_S0     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]   OS_S1     = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]   OS_S2     = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (TICK_PERIOD < 1) begin : g_bad_tick
    $error("uart_rx_os: CLK_FREQ_HZ / (BAUDRATE * OVERSAMPLE) must be at least 1");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 16) begin : g_bad_width
    $error("uart_rx_os: DATA_WIDTH must be in 5..16");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------------
  logic rs_meta;
  logic rs;
  logic rs_prev;

  // NOTE: the synchroniser resets to the idle line level (1). If it reset to 0,
  // every reset release would look like the end of a break.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_meta <= 1'b1;
      rs      <= 1'b1;
      rs_prev <= 1'b1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments. Each
      // stage then samples the value its predecessor held before this edge.
      rs_meta <= rxd;
      rs      <= rs_meta;
      rs_prev <= rs;
    end
  end

  logic fall_edge;
  assign fall_edge = rs_prev & ~rs;

  // ---------------------------------------------------------------------------
  // Tick and oversample counters
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [2:0]        smp;

  logic tick;
  logic samp0;
  logic samp1;
  logic samp2;
  logic bit_end;

  assign tick    = (tick_cnt == TICK_LAST);
  assign samp0   = tick && (os_cnt == OS_S0);
  assign samp1   = tick && (os_cnt == OS_S1);
  assign samp2   = tick && (os_cnt == OS_S2);
  assign bit_end = tick && (os_cnt == OS_LAST);

  // While idle (or parked in BRK), the counters stay at zero. The first
  // cycle of START is therefore oversample slot 0 of the start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
      smp      <= '0;
    end else if (state == S_IDLE || state == S_BRK) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else begin
      if (tick) begin
        tick_cnt <= '0;
        os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (samp0) smp[0] <= rs;
      if (samp1) smp[1] <= rs;
      if (samp2) smp[2] <= rs;
    end
  end

  // ---------------------------------------------------------------------------
  // Majority vote
  // ---------------------------------------------------------------------------
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // vote_end: all three samples are stored; used at the end of a bit.
  // vote_mid: the third sample is taken live; used on the final stop bit,
  //           which completes at its third sample tick.
  logic vote_end;
  logic vote_mid;
  assign vote_end = maj3(smp[0], smp[1], smp[2]);
  assign vote_mid = maj3(smp[0], smp[1], rs);

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] shreg;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic                  par_bit;
  logic                  perr;
  logic                  ferr;

  logic stop_last;
  logic final_stop;
  logic stop_ferr;
  logic par_calc;
  logic is_break;

  assign stop_last  = (stop_cnt == STOP_LAST);
  assign final_stop = (state == S_STOP) && stop_last && samp2;
  // ferr including the final stop vote, which is taken on this same tick.
  assign stop_ferr  = ferr | ~vote_mid;
  // XOR of data and the received parity bit is 1 when the count of ones is odd.
  assign par_calc   = (^shreg) ^ vote_end;
  // par_bit stays 0 when parity is disabled, so it does not block a break.
  assign is_break   = (shreg == '0) && !par_bit && stop_ferr;

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      par_bit    <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      axiod      <= '0;
      axiov      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Strobes and their qualified flags default low; they rise for one cycle.
      axiov      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (fall_edge) begin
            state    <= S_START;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            if (vote_end) begin
              // False start: the line was only a glitch.
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (bit_end) begin
            shreg   <= {vote_end, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            par_bit <= vote_end;
            // Odd parity expects an odd count of ones; even parity expects even.
            perr    <= (PARITY == 1) ? ~par_calc : par_calc;
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (final_stop) begin
            if (is_break) begin
              break_det <= 1'b1;
              state     <= S_BRK;
            end else begin
              axiod      <= shreg;
              axiov      <= 1'b1;
              parity_err <= perr;
              frame_err  <= stop_ferr;
              state      <= S_IDLE;
              busy       <= 1'b0;
            end
          end else if (!stop_last && bit_end) begin
            ferr     <= ferr | ~vote_end;
            stop_cnt <= 1'b1;
          end
        end

        S_BRK: begin
          if (rs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
